// File: rtl/messbauer_diff_discriminator_multichannel_if.sv
//==============================================================================
// Module      : messbauer_diff_discriminator_multichannel_if
// Description : Control/status bundle between the channel generator side and
//               the multichannel differential discriminator generator.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface messbauer_diff_discriminator_multichannel_if #(
    parameter int CHANNEL_COUNT = 512,
    parameter int COUNTER_WIDTH = 16
);
    localparam int CW = $clog2(CHANNEL_COUNT);

    logic                     enable;
    logic                     channel;
    logic [1:0]               mode;
    logic [COUNTER_WIDTH-1:0] impulses_per_channel;
    logic [COUNTER_WIDTH-1:0] select_first;
    logic [COUNTER_WIDTH-1:0] select_last;
    logic                     lower_threshold;
    logic                     upper_threshold;
    logic                     busy;
    logic [CW-1:0]            channel_index;
    logic [COUNTER_WIDTH-1:0] passed_count;
    logic                     channel_done;
    logic                     frame_done;
    logic                     overrun;

    modport master (
        output enable, channel, mode, impulses_per_channel, select_first, select_last,
        input  lower_threshold, upper_threshold, busy, channel_index, passed_count,
               channel_done, frame_done, overrun
    );

    modport slave (
        input  enable, channel, mode, impulses_per_channel, select_first, select_last,
        output lower_threshold, upper_threshold, busy, channel_index, passed_count,
               channel_done, frame_done, overrun
    );
endinterface

`default_nettype wire

// File: rtl/messbauer_diff_discriminator_multichannel.sv
//==============================================================================
// Module      : messbauer_diff_discriminator_multichannel
// Description : Per-channel burst generator of lower/upper discriminator
//               impulses with a selection window and per-channel pass count.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module messbauer_diff_discriminator_multichannel #(
    parameter int GCLK_PERIOD                  = 20,
    parameter int LOWER_THRESHOLD_DURATION     = 3,
    parameter int UPPER_THRESHOLD_DURATION     = 1,
    parameter int DISCRIMINATOR_IMPULSES_PAUSE = 10,
    parameter int CHANNEL_COUNT                = 512,
    parameter int COUNTER_WIDTH                = 16
) (
    input  wire logic aclk,
    input  wire logic areset,
    messbauer_diff_discriminator_multichannel_if.slave bus
);

    localparam int c_CW     = $clog2(CHANNEL_COUNT);
    localparam int c_PH_MAX = (LOWER_THRESHOLD_DURATION > DISCRIMINATOR_IMPULSES_PAUSE) ?
                              LOWER_THRESHOLD_DURATION : DISCRIMINATOR_IMPULSES_PAUSE;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);

    localparam logic [c_CW-1:0]          c_CH_LAST = c_CW'(CHANNEL_COUNT - 1);
    localparam logic [c_CW-1:0]          c_CH_ONE  = c_CW'(1);
    localparam logic [c_PH_W-1:0]        c_L_LAST  = c_PH_W'(LOWER_THRESHOLD_DURATION - 1);
    localparam logic [c_PH_W-1:0]        c_P_LAST  = c_PH_W'(DISCRIMINATOR_IMPULSES_PAUSE - 1);
    localparam logic [c_PH_W-1:0]        c_U_END   = c_PH_W'(UPPER_THRESHOLD_DURATION);
    localparam logic [c_PH_W-1:0]        c_PH_ONE  = c_PH_W'(1);
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_ONE = COUNTER_WIDTH'(1);

    generate
        if (GCLK_PERIOD <= 0 || UPPER_THRESHOLD_DURATION < 1 ||
            LOWER_THRESHOLD_DURATION < UPPER_THRESHOLD_DURATION + 2 ||
            DISCRIMINATOR_IMPULSES_PAUSE < 1 || CHANNEL_COUNT < 2) begin : g_param_check
            $error("messbauer_diff_discriminator_multichannel: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_LOWER_HIGH = 2'd1,
        S_PAUSE      = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_PH_W-1:0]        r_ph_cnt;
    logic [c_PH_W-1:0]        w_ph_nxt;
    logic [COUNTER_WIDTH-1:0] r_imp_idx;
    logic [COUNTER_WIDTH-1:0] w_idx_nxt;
    logic [COUNTER_WIDTH-1:0] w_idx_inc;

    logic                     r_sync1, r_sync2, r_sync3, r_edge;
    logic [1:0]               r_mode;
    logic [COUNTER_WIDTH-1:0] r_n, r_first, r_last;

    logic                     r_lower, r_upper, r_busy, r_channel_done, r_frame_done, r_overrun;
    logic [c_CW-1:0]          r_chan;
    logic [COUNTER_WIDTH-1:0] r_passed;
    logic                     r_first_flag, r_burst_last;

    logic                     w_accept, w_busy_edge, w_pass, w_count_pass, w_end, w_upper_nxt;
    logic [c_CW-1:0]          w_chan_adv;

    assign w_accept    = r_edge && bus.enable && (r_state == S_IDLE);
    assign w_busy_edge = r_edge && (r_state != S_IDLE);
    assign w_idx_inc   = r_imp_idx + c_CNT_ONE;

    always_comb begin
        w_chan_adv = r_chan + c_CH_ONE;
        if (r_first_flag || (r_chan == c_CH_LAST)) begin
            w_chan_adv = '0;
        end
    end

    // Mode 3 deliberately falls into the window branch alongside mode 0.
    always_comb begin
        w_pass = 1'b0;
        case (r_mode)
            2'd1:    w_pass = 1'b1;
            2'd2:    w_pass = 1'b0;
            default: w_pass = (r_first <= r_imp_idx) && (r_imp_idx <= r_last);
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_ph_cnt  <= '0;
            r_imp_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph_cnt  <= w_ph_nxt;
            r_imp_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ph_nxt     = r_ph_cnt;
        w_idx_nxt    = r_imp_idx;
        w_count_pass = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (bus.impulses_per_channel != '0)) begin
                    w_state_nxt = S_LOWER_HIGH;
                    w_ph_nxt    = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_LOWER_HIGH: begin
                if (r_ph_cnt == c_L_LAST) begin
                    w_state_nxt  = S_PAUSE;
                    w_ph_nxt     = '0;
                    w_count_pass = w_pass;
                end else begin
                    w_ph_nxt = r_ph_cnt + c_PH_ONE;
                end
            end
            S_PAUSE: begin
                if (r_ph_cnt == c_P_LAST) begin
                    w_ph_nxt = '0;
                    if (w_idx_inc < r_n) begin
                        w_state_nxt = S_LOWER_HIGH;
                        w_idx_nxt   = w_idx_inc;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_end       = 1'b1;
                    end
                end else begin
                    w_ph_nxt = r_ph_cnt + c_PH_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ph_nxt    = '0;
            end
        endcase
    end

    // Only cycles 1..U of a rejected impulse carry the upper pulse; cycle 0 never does.
    assign w_upper_nxt = (w_state_nxt == S_LOWER_HIGH) && (w_ph_nxt >= c_PH_ONE) &&
                         (w_ph_nxt <= c_U_END) && !w_pass;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_sync3        <= 1'b0;
            r_edge         <= 1'b0;
            r_mode         <= '0;
            r_n            <= '0;
            r_first        <= '0;
            r_last         <= '0;
            r_lower        <= 1'b0;
            r_upper        <= 1'b0;
            r_busy         <= 1'b0;
            r_channel_done <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overrun      <= 1'b0;
            r_chan         <= '0;
            r_passed       <= '0;
            r_first_flag   <= 1'b1;
            r_burst_last   <= 1'b0;
        end else begin
            r_sync1        <= bus.channel;
            r_sync2        <= r_sync1;
            r_sync3        <= r_sync2;
            r_edge         <= r_sync2 && !r_sync3;
            r_lower        <= (w_state_nxt == S_LOWER_HIGH);
            r_upper        <= w_upper_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_channel_done <= 1'b0;
            r_frame_done   <= 1'b0;
            if (w_accept) begin
                r_mode       <= bus.mode;
                r_n          <= bus.impulses_per_channel;
                r_first      <= bus.select_first;
                r_last       <= bus.select_last;
                r_chan       <= w_chan_adv;
                r_first_flag <= 1'b0;
                r_passed     <= '0;
                r_burst_last <= (w_chan_adv == c_CH_LAST);
                if (bus.impulses_per_channel == '0) begin
                    r_channel_done <= 1'b1;
                    r_frame_done   <= (w_chan_adv == c_CH_LAST);
                end
            end else begin
                if (w_busy_edge) begin
                    r_overrun <= 1'b1;
                    r_chan    <= w_chan_adv;
                end
                if (w_count_pass && (r_passed != '1)) begin
                    r_passed <= r_passed + c_CNT_ONE;
                end
                if (w_end) begin
                    r_channel_done <= 1'b1;
                    r_frame_done   <= r_burst_last;
                end
            end
        end
    end

    assign bus.lower_threshold = r_lower;
    assign bus.upper_threshold = r_upper;
    assign bus.busy            = r_busy;
    assign bus.channel_index   = r_chan;
    assign bus.passed_count    = r_passed;
    assign bus.channel_done    = r_channel_done;
    assign bus.frame_done      = r_frame_done;
    assign bus.overrun         = r_overrun;

endmodule

`default_nettype wire
